// File: rtl/dmem_access_arbiter.sv
// Single-ported data memory sequencer shared by the pipeline load/store port and a DMA/debug port.
// Round-robin arbitration, registered strobes held until mem_ready, one-cycle completion pulses.
module dmem_access_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_ack,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_ACC} state_t;

   state_t            state_q, state_d;
   logic              last_dma_q, last_dma_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
   logic              cpu_done_q, cpu_done_d;
   logic              dma_ack_q, dma_ack_d;

   logic cpu_req, cpu_elig, dma_elig, grant_cpu, grant_dma;

   // A requester still shows its old request in its own completion cycle.
   assign cpu_req   = cpu_read | cpu_write;
   assign cpu_elig  = cpu_req & ~cpu_done_q;
   assign dma_elig  = dma_req & ~dma_ack_q;
   assign grant_cpu = cpu_elig & (~dma_elig | last_dma_q);
   assign grant_dma = dma_elig & ~grant_cpu;

   always_comb begin
      state_d     = state_q;
      last_dma_d  = last_dma_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dma_rdata_d = dma_rdata_q;
      cpu_done_d  = 1'b0;
      dma_ack_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_cpu) begin
               mem_addr_d  = cpu_addr;
               mem_wdata_d = cpu_wdata;
               mem_write_d = cpu_write;
               mem_read_d  = ~cpu_write;
               last_dma_d  = 1'b0;
               state_d     = CPU_ACC;
            end else if (grant_dma) begin
               mem_addr_d  = dma_addr;
               mem_wdata_d = dma_wdata;
               mem_write_d = dma_we;
               mem_read_d  = ~dma_we;
               last_dma_d  = 1'b1;
               state_d     = DMA_ACC;
            end
         end
         CPU_ACC: begin
            if (mem_ready) begin
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               cpu_rdata_d = mem_rdata;
               cpu_done_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         DMA_ACC: begin
            if (mem_ready) begin
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               dma_rdata_d = mem_rdata;
               dma_ack_d   = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // last_grant starts at DMA so the CPU wins the first tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         last_dma_q  <= 1'b1;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
         cpu_done_q  <= 1'b0;
         dma_ack_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_dma_q  <= last_dma_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
         cpu_done_q  <= cpu_done_d;
         dma_ack_q   <= dma_ack_d;
      end
   end

   assign cpu_stall = cpu_req & ~cpu_done_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dma_rdata = dma_rdata_q;
   assign dma_ack   = dma_ack_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Directed bench for dmem_access_arbiter: vector table of single accesses plus
// hand-written reset, arbitration and held-request sequences against a small memory model.
module tb_dmem_access_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;

   typedef struct {
      bit          dma;
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waits;
      bit          chk_rdata;
      logic [31:0] exp_rdata;
      int          exp_lat;
      int          exp_rd;
      int          exp_wr;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_read, cpu_write;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata;
   logic          cpu_stall;
   logic          dma_req, dma_we;
   logic [AW-1:0] dma_addr;
   logic [DW-1:0] dma_wdata, dma_rdata;
   logic          dma_ack;
   logic          mem_read, mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          mem_ready;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem_arr [0:255];
   int          wait_cfg = 0;
   int          wcnt = 0;
   logic        prev_stb = 1'b0;
   logic [31:0] prev_addr = '0;
   vec_t        vecs [8];

   dmem_access_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset),
      .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
      .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   // Memory model: ready after wait_cfg extra strobe cycles.
   assign mem_ready = (mem_read | mem_write) && (wcnt == wait_cfg);
   assign mem_rdata = mem_arr[mem_addr[7:0]];

   always @(posedge clk) begin
      if ((mem_read | mem_write) && !mem_ready) wcnt <= wcnt + 1;
      else wcnt <= 0;
      if (mem_write && mem_ready) mem_arr[mem_addr[7:0]] = mem_wdata;
   end

   // Strobe exclusivity and address stability throughout every access.
   always @(negedge clk) begin
      if (!reset) begin
         total++;
         if (mem_read && mem_write) begin
            bad++;
            $display("FAIL strobe_excl: read=%0b write=%0b, required never both", mem_read, mem_write);
         end
         if (prev_stb && (mem_read || mem_write)) begin
            total++;
            if (mem_addr !== prev_addr) begin
               bad++;
               $display("FAIL addr_stable: got %08h required %08h", mem_addr, prev_addr);
            end
         end
      end
      prev_stb  <= (mem_read | mem_write) & ~reset;
      prev_addr <= mem_addr;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h required %08h", name, act, exp);
      end
   endtask

   task automatic drop_reqs();
      cpu_read  = 1'b0;
      cpu_write = 1'b0;
      dma_req   = 1'b0;
      dma_we    = 1'b0;
   endtask

   // Called just after a rising edge; returns just after a rising edge.
   task automatic run_vec(input int idx, input vec_t v);
      int          c;
      int          rd_n;
      int          wr_n;
      bit          done_seen;
      bit          wdata_ok;
      logic [31:0] rdat;
      rd_n = 0; wr_n = 0; done_seen = 0; wdata_ok = 1; rdat = '0;
      wait_cfg = v.waits;
      if (v.dma) begin
         dma_req = 1'b1; dma_we = v.wr; dma_addr = v.addr; dma_wdata = v.wdata;
      end else begin
         cpu_read = v.rd; cpu_write = v.wr; cpu_addr = v.addr; cpu_wdata = v.wdata;
      end
      for (c = 0; c < 40; c++) begin
         @(negedge clk);
         if (v.dma ? dma_ack : !cpu_stall) begin
            done_seen = 1;
            rdat = v.dma ? dma_rdata : cpu_rdata;
            break;
         end
         if (mem_read) rd_n++;
         if (mem_write) begin
            wr_n++;
            if (mem_wdata !== v.wdata) wdata_ok = 0;
         end
      end
      drop_reqs();
      if (!done_seen) begin
         chk($sformatf("v%0d_timeout", idx), 32'(c), 32'(v.exp_lat));
      end else begin
         chk($sformatf("v%0d_latency", idx), 32'(c), 32'(v.exp_lat));
         chk($sformatf("v%0d_read_cycles", idx), 32'(rd_n), 32'(v.exp_rd));
         chk($sformatf("v%0d_write_cycles", idx), 32'(wr_n), 32'(v.exp_wr));
         if (v.wr) chk($sformatf("v%0d_wdata_ok", idx), 32'(wdata_ok), 32'd1);
         if (v.chk_rdata) chk($sformatf("v%0d_rdata", idx), rdat, v.exp_rdata);
      end
      @(negedge clk);
      chk($sformatf("v%0d_idle_strobes", idx), 32'({mem_read, mem_write}), 32'd0);
      chk($sformatf("v%0d_ack_single", idx), 32'(dma_ack), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      //        dma rd wr  addr        wdata        w  chk exp_rdata    lat rd wr
      vecs[0] = '{0, 1, 0, 32'h40, 32'h0,        0, 1, 32'hDEADBEEF, 2, 1, 0};
      vecs[1] = '{0, 0, 1, 32'h80, 32'h12345678, 3, 0, 32'h0,        5, 0, 4};
      vecs[2] = '{1, 0, 1, 32'h10, 32'hA5A5A5A5, 0, 0, 32'h0,        2, 0, 1};
      vecs[3] = '{1, 1, 0, 32'h10, 32'h0,        1, 1, 32'hA5A5A5A5, 3, 2, 0};
      vecs[4] = '{0, 1, 1, 32'h20, 32'hCAFEF00D, 0, 0, 32'h0,        2, 0, 1};
      vecs[5] = '{0, 1, 0, 32'h20, 32'h0,        2, 1, 32'hCAFEF00D, 4, 3, 0};
      vecs[6] = '{0, 1, 0, 32'h80, 32'h0,        0, 1, 32'h12345678, 2, 1, 0};
      vecs[7] = '{1, 1, 0, 32'h40, 32'h0,        0, 1, 32'hDEADBEEF, 2, 1, 0};

      for (int i = 0; i < 256; i++) mem_arr[i] = '0;
      mem_arr[8'h40] = 32'hDEADBEEF;

      reset = 1'b1;
      drop_reqs();
      cpu_addr = '0; cpu_wdata = '0; dma_addr = '0; dma_wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_read", 32'(mem_read), 32'd0);
      chk("rst_mem_write", 32'(mem_write), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_cpu_rdata", cpu_rdata, 32'd0);
      chk("rst_dma_rdata", dma_rdata, 32'd0);
      chk("rst_dma_ack", 32'(dma_ack), 32'd0);
      chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

      // Reset in the middle of a CPU access.
      wait_cfg = 5;
      cpu_read = 1'b1; cpu_addr = 32'h40;
      @(negedge clk);
      @(negedge clk);
      chk("rstmid_read_before", 32'(mem_read), 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("rstmid_read_drop", 32'(mem_read), 32'd0);
      chk("rstmid_addr_clear", mem_addr, 32'd0);
      chk("rstmid_cpu_rdata", cpu_rdata, 32'd0);
      chk("rstmid_dma_rdata", dma_rdata, 32'd0);
      cpu_read = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("rstmid_quiet_%0d", i), {cpu_rdata[30:0], mem_read | mem_write}, 32'd0);
      end
      @(posedge clk);
      #1;

      // Simultaneous pair right after reset: CPU first, DMA in the CPU done cycle.
      wait_cfg = 0;
      cpu_read = 1'b1; cpu_addr = 32'h40;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h10;
      @(negedge clk);
      @(negedge clk);
      chk("arb1_c1_read", 32'(mem_read), 32'd1);
      chk("arb1_c1_addr", mem_addr, 32'h40);
      @(negedge clk);
      chk("arb1_c2_stall", 32'(cpu_stall), 32'd0);
      chk("arb1_c2_rdata", cpu_rdata, 32'hDEADBEEF);
      cpu_read = 1'b0;
      @(negedge clk);
      chk("arb1_c3_read", 32'(mem_read), 32'd1);
      chk("arb1_c3_addr", mem_addr, 32'h10);
      @(negedge clk);
      chk("arb1_c4_ack", 32'(dma_ack), 32'd1);
      chk("arb1_c4_rdata", dma_rdata, 32'hA5A5A5A5);
      dma_req = 1'b0;
      @(posedge clk);
      #1;

      // Lone CPU access makes CPU the last grant, so the next tie goes to DMA.
      run_vec(8, vecs[6]);
      cpu_read = 1'b1; cpu_addr = 32'h40;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h10;
      @(negedge clk);
      @(negedge clk);
      chk("arb2_c1_addr", mem_addr, 32'h10);
      chk("arb2_c1_stall", 32'(cpu_stall), 32'd1);
      @(negedge clk);
      chk("arb2_c2_ack", 32'(dma_ack), 32'd1);
      chk("arb2_c2_stall", 32'(cpu_stall), 32'd1);
      dma_req = 1'b0;
      @(negedge clk);
      chk("arb2_c3_addr", mem_addr, 32'h40);
      chk("arb2_c3_read", 32'(mem_read), 32'd1);
      @(negedge clk);
      chk("arb2_c4_stall", 32'(cpu_stall), 32'd0);
      chk("arb2_c4_rdata", cpu_rdata, 32'hDEADBEEF);
      cpu_read = 1'b0;
      @(posedge clk);
      #1;

      // Held DMA request is not re-granted in its ack cycle.
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h10;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("hold_c2_ack", 32'(dma_ack), 32'd1);
      @(negedge clk);
      chk("hold_c3_strobes", 32'({mem_read, mem_write}), 32'd0);
      chk("hold_c3_ack", 32'(dma_ack), 32'd0);
      dma_req = 1'b0;
      @(negedge clk);
      chk("hold_c4_strobes", 32'({mem_read, mem_write}), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
